// File: rtl/bist_fail_log.sv
// Fail logger for the RAM BIST engine: saturating fail count, FIFO of the first DEPTH
// failures (address + syndrome), run status, and post-run readout of logged entries.
module bist_fail_log #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LCW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done_in,
    input  logic              fail_vld,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic [DATA_W-1:0] fail_exp,
    input  logic [DATA_W-1:0] fail_act,
    input  logic              rd_req,
    output logic              rd_vld,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_syn,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [LCW-1:0]    log_cnt,
    output logic [7:0]        status
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int ENT_W = ADDR_W + DATA_W;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [LCW-1:0]     log_cnt_reg, log_cnt_next;
    logic [CNT_W-1:0]   fail_cnt_reg, fail_cnt_next;
    logic               ovf_reg, ovf_next;
    logic               rd_vld_reg;
    logic [ADDR_W-1:0]  rd_addr_reg;
    logic [DATA_W-1:0]  rd_syn_reg;
    logic [7:0]         status_reg, status_next;
    logic               push, pop;

    logic [ENT_W-1:0]   mem [DEPTH];

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        log_cnt_next  = log_cnt_reg;
        fail_cnt_next = fail_cnt_reg;
        ovf_next      = ovf_reg;
        push          = 1'b0;
        pop           = 1'b0;

        if (start) begin
            // start wins over everything, including a same-cycle fail or pop
            state_next    = RUN;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            log_cnt_next  = '0;
            fail_cnt_next = '0;
            ovf_next      = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (fail_vld) begin
                        if (fail_cnt_reg != '1)
                            fail_cnt_next = fail_cnt_reg + CNT_W'(1);
                        if (log_cnt_reg != LCW'(DEPTH)) begin
                            push         = 1'b1;
                            wr_ptr_next  = wr_ptr_reg + PTR_W'(1);
                            log_cnt_next = log_cnt_reg + LCW'(1);
                        end else begin
                            ovf_next = 1'b1;
                        end
                    end
                    if (done_in)
                        state_next = DONE;
                end
                DONE: begin
                    if (rd_req && log_cnt_reg != '0) begin
                        pop          = 1'b1;
                        rd_ptr_next  = rd_ptr_reg + PTR_W'(1);
                        log_cnt_next = log_cnt_reg - LCW'(1);
                    end
                end
                IDLE: ;
                default: state_next = IDLE;
            endcase
        end

        status_next = {2'b00,
                       log_cnt_next == LCW'(DEPTH),
                       ovf_next,
                       fail_cnt_next != '0,
                       (state_next == DONE) && (fail_cnt_next == '0),
                       state_next};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            log_cnt_reg  <= '0;
            fail_cnt_reg <= '0;
            ovf_reg      <= 1'b0;
            rd_vld_reg   <= 1'b0;
            rd_addr_reg  <= '0;
            rd_syn_reg   <= '0;
            status_reg   <= 8'h00;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            log_cnt_reg  <= log_cnt_next;
            fail_cnt_reg <= fail_cnt_next;
            ovf_reg      <= ovf_next;
            status_reg   <= status_next;
            rd_vld_reg   <= pop;
            // Output data holds its last value unless a pop is accepted
            if (pop) begin
                rd_addr_reg <= mem[rd_ptr_reg][ENT_W-1:DATA_W];
                rd_syn_reg  <= mem[rd_ptr_reg][DATA_W-1:0];
            end
        end
    end

    // Log storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {fail_addr, fail_exp ^ fail_act};
    end

    assign rd_vld   = rd_vld_reg;
    assign rd_addr  = rd_addr_reg;
    assign rd_syn   = rd_syn_reg;
    assign fail_cnt = fail_cnt_reg;
    assign log_cnt  = log_cnt_reg;
    assign status   = status_reg;

endmodule
